// File: rtl/fpu_pkg.sv
// Shared constants and types for the memory-mapped binary32 FPU.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fpu_pkg;

  // Opcodes held in the OPCODE register
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Word addresses of the register map
  localparam logic [1:0] ADDR_OPA    = 2'd0;
  localparam logic [1:0] ADDR_OPB    = 2'd1;
  localparam logic [1:0] ADDR_OPCODE = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  // Canonical special results
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  // binary32 field view
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

endpackage

// File: rtl/fpu_core.sv
// Combinational binary32 add/sub/mul/div with round-to-nearest-even and flush-to-zero.
// Latency: zero cycles; y follows a, b and op combinationally.
// Backpressure: none; pure function of its inputs.
// Ports: a, b (operands), op (opcode), y (result).
module fpu_core (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [31:0] y
);
  import fpu_pkg::*;

  fp32_t fa_s, fb_s;
  assign fa_s = a;
  assign fb_s = b;

  logic        sa, sb, sbe;
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic [23:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sa  = fa_s.sign;
  assign sb  = fb_s.sign;
  // Subtraction is addition with OPB's sign inverted
  assign sbe = sb ^ (op == OP_SUB);
  assign ea  = fa_s.exp;
  assign eb  = fb_s.exp;
  assign ma  = fa_s.man;
  assign mb  = fb_s.man;
  assign fa  = {1'b1, ma};
  assign fb  = {1'b1, mb};

  // Exponent zero covers subnormals too: they behave as signed zero
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (ma == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (mb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (ma != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (mb != 23'd0);

  // Round-to-nearest-even then range check; one instance shared by all ops
  function automatic logic [31:0] round_pack(input logic s, input logic signed [10:0] e,
                                             input logic [23:0] m, input logic g, input logic st);
    logic               inc;
    logic               carry;
    logic [22:0]        frac;
    logic signed [10:0] er;
    inc   = g & (st | m[0]);
    carry = inc & (&m);
    // On carry the fraction wraps to zero, which is exactly 1.0 at exponent+1
    frac  = m[22:0] + {22'd0, inc};
    er    = carry ? e + 11'sd1 : e;
    if (er >= 11'sd255)
      return s ? NEG_INF : POS_INF;
    else if (er <= 11'sd0)
      return {s, 31'd0};
    else
      return {s, er[7:0], frac};
  endfunction

  // ---------------- add / sub ----------------
  logic               a_big, sl, ss;
  logic [7:0]         el, es, ediff;
  logic [23:0]        ml, ms;
  logic [4:0]         dsh, lz;
  logic [49:0]        algn;
  logic [27:0]        lx, sx, sum;
  logic [26:0]        nrm;
  logic signed [10:0] e_add;
  logic               add_zero;

  always_comb begin
    a_big = ({ea, ma} >= {eb, mb});
    el    = a_big ? ea  : eb;
    es    = a_big ? eb  : ea;
    ml    = a_big ? fa  : fb;
    ms    = a_big ? fb  : fa;
    sl    = a_big ? sa  : sbe;
    ss    = a_big ? sbe : sa;
    ediff = el - es;
    // Beyond 31 places the smaller operand only contributes sticky
    dsh   = (ediff > 8'd31) ? 5'd31 : ediff[4:0];
    algn  = {ms, 26'd0} >> dsh;
    // [27] carry, [26:3] significand, [2] guard, [1] round, [0] sticky
    lx    = {1'b0, ml, 3'b000};
    sx    = {1'b0, algn[49:24], |algn[23:0]};
    sum   = (sl != ss) ? lx - sx : lx + sx;
    add_zero = (sum == 28'd0);
    lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);
    if (sum[27]) begin
      nrm   = {sum[27:2], sum[1] | sum[0]};
      e_add = $signed({3'b000, el}) + 11'sd1;
    end else begin
      // Large left shifts only occur for ediff <= 1, where low bits are exact
      nrm   = sum[26:0] << lz;
      e_add = $signed({3'b000, el}) - $signed({6'b000000, lz});
    end
  end

  // ---------------- multiply ----------------
  logic [47:0]        prod;
  logic signed [10:0] e_mul;
  logic [23:0]        m_mul;
  logic               g_mul, st_mul;

  always_comb begin
    prod  = {24'd0, fa} * {24'd0, fb};
    e_mul = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127
          + (prod[47] ? 11'sd1 : 11'sd0);
    if (prod[47]) begin
      m_mul  = prod[47:24];
      g_mul  = prod[23];
      st_mul = |prod[22:0];
    end else begin
      m_mul  = prod[46:23];
      g_mul  = prod[22];
      st_mul = |prod[21:0];
    end
  end

  // ---------------- divide (restoring) ----------------
  logic [24:0]        rem;
  logic [25:0]        quo;
  logic signed [10:0] e_div;
  logic [23:0]        m_div;
  logic               g_div, st_div;

  always_comb begin
    rem = {1'b0, fa};
    quo = 26'd0;
    // Remainder stays below 2*fb, so each step yields one quotient bit
    for (int i = 25; i >= 0; i--) begin
      if (rem >= {1'b0, fb}) begin
        quo[i] = 1'b1;
        rem    = rem - {1'b0, fb};
      end
      rem = rem << 1;
    end
    e_div = $signed({3'b000, ea}) - $signed({3'b000, eb})
          + (quo[25] ? 11'sd127 : 11'sd126);
    if (quo[25]) begin
      m_div  = quo[25:2];
      g_div  = quo[1];
      st_div = quo[0] | (rem != 25'd0);
    end else begin
      m_div  = quo[24:1];
      g_div  = quo[0];
      st_div = (rem != 25'd0);
    end
  end

  // ---------------- shared rounding ----------------
  logic               r_s, r_g, r_st;
  logic signed [10:0] r_e;
  logic [23:0]        r_m;
  logic [31:0]        rounded;

  always_comb begin
    r_s  = sl;
    r_e  = e_add;
    r_m  = nrm[26:3];
    r_g  = nrm[2];
    r_st = nrm[1] | nrm[0];
    if (op == OP_MUL) begin
      r_s = sa ^ sb; r_e = e_mul; r_m = m_mul; r_g = g_mul; r_st = st_mul;
    end else if (op == OP_DIV) begin
      r_s = sa ^ sb; r_e = e_div; r_m = m_div; r_g = g_div; r_st = st_div;
    end
  end

  assign rounded = round_pack(r_s, r_e, r_m, r_g, r_st);

  // ---------------- special cases ----------------
  logic s_md;
  assign s_md = sa ^ sb;

  always_comb begin
    y = rounded;
    unique case (op)
      OP_ADD, OP_SUB: begin
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sbe))) y = QNAN;
        else if (a_inf)              y = sa  ? NEG_INF : POS_INF;
        else if (b_inf)              y = sbe ? NEG_INF : POS_INF;
        else if (a_zero && b_zero)   y = 32'd0;
        else if (a_zero)             y = {sbe, b[30:0]};
        else if (b_zero)             y = a;
        else if (add_zero)           y = 32'd0;
      end
      OP_MUL: begin
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) y = QNAN;
        else if (a_inf || b_inf)     y = s_md ? NEG_INF : POS_INF;
        else if (a_zero || b_zero)   y = {s_md, 31'd0};
      end
      OP_DIV: begin
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) y = QNAN;
        else if (a_inf || b_zero)    y = s_md ? NEG_INF : POS_INF;
        else if (a_zero || b_inf)    y = {s_md, 31'd0};
      end
      default: y = rounded;
    endcase
  end

endmodule

// File: rtl/fpu_wrapper.sv
// Memory-mapped FPU: OPA/OPB/OPCODE registers, combinational core, registered RESULT.
// Latency: an operand/opcode write at edge N is visible in RESULT after edge N+1.
// Backpressure: none; writes always accepted, reads combinational, no busy flag.
// Ports: Clk, RstN (active-high async reset), ChipSelect, Write, Read, Address[1:0],
//        WriteData[31:0], ReadData[31:0].
module fpu_wrapper (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        ChipSelect,
  input  logic        Write,
  input  logic        Read,
  input  logic [1:0]  Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData
);
  import fpu_pkg::*;

  logic [31:0] opa, opb, result, core_y;
  logic [1:0]  opcode;
  logic        wr_en, rd_en;

  assign wr_en = ChipSelect & Write;
  // A simultaneous write wins: the read port returns zero
  assign rd_en = ChipSelect & Read & ~Write;

  fpu_core u_core (
    .a  (opa),
    .b  (opb),
    .op (opcode),
    .y  (core_y)
  );

  always_ff @(posedge Clk or posedge RstN) begin
    if (RstN) begin
      opa    <= 32'd0;
      opb    <= 32'd0;
      opcode <= 2'd0;
      result <= 32'd0;
    end else begin
      if (wr_en) begin
        unique case (Address)
          ADDR_OPA:    opa    <= WriteData;
          ADDR_OPB:    opb    <= WriteData;
          ADDR_OPCODE: opcode <= WriteData[1:0];
          default:     ; // RESULT is read-only
        endcase
      end
      // Free-running capture: no start command
      result <= core_y;
    end
  end

  always_comb begin
    ReadData = 32'd0;
    if (rd_en) begin
      unique case (Address)
        ADDR_OPA:    ReadData = opa;
        ADDR_OPB:    ReadData = opb;
        ADDR_OPCODE: ReadData = {30'd0, opcode};
        default:     ReadData = result;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_wrapper.sv
module tb_fpu_wrapper;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        cs    = 1'b0;
  logic        wr    = 1'b0;
  logic        rd    = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  fpu_wrapper dut (
    .Clk        (clk),
    .RstN       (rst),
    .ChipSelect (cs),
    .Write      (wr),
    .Read       (rd),
    .Address    (addr),
    .WriteData  (wdata),
    .ReadData   (rdata)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] y;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Write occupies exactly one rising edge, then returns at the following negedge
  task automatic bus_wr(input logic [1:0] ad, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = ad; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd_now(input logic [1:0] ad, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = ad;
    #2;
    d = rdata;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] ad, output logic [31:0] d);
    @(negedge clk);
    bus_rd_now(ad, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;

    vecs[0]  = '{32'h404EB852, 32'h3FC00000, 2'd0, 32'h40975C29}; // 3.23+1.5
    vecs[1]  = '{32'h404EB852, 32'h3FC00000, 2'd1, 32'h3FDD70A4}; // 3.23-1.5 = 1.73
    vecs[2]  = '{32'h404EB852, 32'h3FC00000, 2'd2, 32'h409B0A3E}; // tie to even
    vecs[3]  = '{32'h404EB852, 32'h3FC00000, 2'd3, 32'h4009D037};
    vecs[4]  = '{32'h3F800000, 32'h00000000, 2'd3, 32'h7F800000}; // 1/0
    vecs[5]  = '{32'h00000000, 32'h00000000, 2'd3, 32'h7FC00000}; // 0/0
    vecs[6]  = '{32'h7F7FFFFF, 32'h40000000, 2'd2, 32'h7F800000}; // overflow
    vecs[7]  = '{32'h3F800000, 32'hBF800000, 2'd0, 32'h00000000}; // exact zero sum
    vecs[8]  = '{32'h7F800000, 32'h7F800000, 2'd1, 32'h7FC00000}; // Inf-Inf
    vecs[9]  = '{32'h00000000, 32'h7F800000, 2'd2, 32'h7FC00000}; // 0*Inf
    vecs[10] = '{32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000}; // NaN in
    vecs[11] = '{32'hC0000000, 32'h40400000, 2'd2, 32'hC0C00000}; // -2*3
    vecs[12] = '{32'h3F800000, 32'h40400000, 2'd3, 32'h3EAAAAAB}; // 1/3
    vecs[13] = '{32'h00800000, 32'h00800000, 2'd2, 32'h00000000}; // underflow
    vecs[14] = '{32'h80800000, 32'h00800000, 2'd2, 32'h80000000}; // signed underflow
    vecs[15] = '{32'h00000001, 32'h3F800000, 2'd0, 32'h3F800000}; // subnormal as 0
    vecs[16] = '{32'h3F800000, 32'h80000000, 2'd3, 32'hFF800000}; // 1/-0
    vecs[17] = '{32'h7F800000, 32'h7F800000, 2'd3, 32'h7FC00000}; // Inf/Inf
    vecs[18] = '{32'h3F800000, 32'h33800000, 2'd0, 32'h3F800000}; // tie, even stays
    vecs[19] = '{32'h3F800000, 32'h33C00000, 2'd0, 32'h3F800001}; // above half
    vecs[20] = '{32'h3F800001, 32'h33800000, 2'd0, 32'h3F800002}; // tie, odd rounds up
    vecs[21] = '{32'h3F800000, 32'h3FC00000, 2'd1, 32'hBF000000}; // 1-1.5

    // Reset state
    repeat (2) @(negedge clk);
    bus_rd_now(2'd0, r); check("rst_opa_during", r, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_rd(2'(k), r);
      check($sformatf("reset_addr%0d", k), r, 32'd0);
    end

    // Table-driven arithmetic
    for (int i = 0; i < NVEC; i++) begin
      bus_wr(2'd0, vecs[i].a);
      bus_wr(2'd1, vecs[i].b);
      bus_wr(2'd2, {30'd0, vecs[i].op});
      bus_rd(2'd3, r);
      check($sformatf("vec%0d", i), r, vecs[i].y);
    end

    // Latency: RESULT still holds the old value before the next edge
    bus_wr(2'd0, 32'h3F800000);
    bus_wr(2'd1, 32'h40000000);
    bus_wr(2'd2, 32'd0);
    bus_rd(2'd3, r);        check("lat_add", r, 32'h40400000);
    bus_wr(2'd2, 32'd2);
    bus_rd_now(2'd3, r);    check("lat_old_result", r, 32'h40400000);
    bus_rd(2'd3, r);        check("lat_new_result", r, 32'h40000000);

    // Operand write recomputes with the held opcode
    bus_wr(2'd0, 32'h40400000);
    bus_rd(2'd3, r);        check("held_op_mul", r, 32'h40C00000);

    // RESULT is read-only
    bus_wr(2'd3, 32'hDEADBEEF);
    bus_rd(2'd3, r);        check("result_ro", r, 32'h40C00000);

    // OPCODE keeps only two bits; operand readback
    bus_wr(2'd2, 32'hFFFFFFFE);
    bus_rd(2'd2, r);        check("opcode_trunc", r, 32'd2);
    bus_rd(2'd0, r);        check("opa_readback", r, 32'h40400000);

    // Read without chip select
    @(negedge clk);
    cs = 1'b0; rd = 1'b1; addr = 2'd3;
    #2;
    check("read_no_cs", rdata, 32'd0);
    rd = 1'b0;

    // Simultaneous read and write: write lands, read returns zero
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 2'd1; wdata = 32'h3F800000;
    #2;
    check("rw_readdata", rdata, 32'd0);
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    bus_rd(2'd1, r);        check("rw_write_took", r, 32'h3F800000);
    bus_rd(2'd3, r);        check("rw_result", r, 32'h40400000);

    // Asynchronous reset mid-sequence
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      bus_rd_now(2'(k), r);
      check($sformatf("midrst_addr%0d", k), r, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_rd_now(2'd3, r);    check("post_rst_result", r, 32'd0);
    bus_rd(2'd3, r);        check("post_rst_zero_sum", r, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
